// File: rtl/usb_serial_fifo_bridge_if.sv
// CPU bus and byte-stream core signals of the USB serial FIFO bridge.
// The slave modport is the bridge side; the master modport drives it.
interface usb_serial_fifo_bridge_if #(
  parameter int DATA_W = 8
);
  logic              cs_n;
  logic              rd_n;
  logic              wr_n;
  logic [2:0]        addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              irq_n;
  logic              core_tx_ready;
  logic              core_tx_strobe;
  logic [DATA_W-1:0] core_tx_data;
  logic              core_rx_strobe;
  logic [DATA_W-1:0] core_rx_data;

  modport slave (
    input  cs_n, rd_n, wr_n, addr, data_in, core_tx_ready, core_rx_strobe, core_rx_data,
    output data_out, irq_n, core_tx_strobe, core_tx_data
  );

  modport master (
    output cs_n, rd_n, wr_n, addr, data_in, core_tx_ready, core_rx_strobe, core_rx_data,
    input  data_out, irq_n, core_tx_strobe, core_tx_data
  );
endinterface

// File: rtl/usb_serial_fifo_bridge.sv
// Z80 I/O peripheral fronting a byte-stream core with TX/RX FIFOs,
// an automatic TX drain FSM, RX overrun flag and a maskable interrupt.
module usb_serial_fifo_bridge #(
  parameter int TX_AW  = 4,
  parameter int RX_AW  = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  usb_serial_fifo_bridge_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} txState_t;

  logic              w_readSel, w_writeSel, w_wrPulse, w_rdEnd;
  logic              r_readSelQ, r_writeSelQ;
  logic [2:0]        r_rdAddr, w_rdAddr;
  logic              w_ctrlWr, w_txFlush, w_rxFlush, w_overrunClr;
  logic              r_rxIrqEn, r_txIrqEn, r_overrun, r_irqN;

  logic [DATA_W-1:0] r_rxMem [2**RX_AW];
  logic [RX_AW:0]    r_rxWr, r_rxRd, w_rxCount;
  logic              w_rxEmpty, w_rxFull, w_rxPush, w_rxPop, w_rxDrop;

  logic [DATA_W-1:0] r_txMem [2**TX_AW];
  logic [TX_AW:0]    r_txWr, r_txRd, w_txFree;
  logic              w_txEmpty, w_txFull, w_txPush, w_txPop;

  txState_t          r_state;
  logic              r_txStrobe;
  logic [DATA_W-1:0] r_txData;
  logic              w_irqPending;
  logic [DATA_W-1:0] w_rdData;

  assign w_readSel  = !bus.cs_n && !bus.rd_n && bus.wr_n;
  assign w_writeSel = !bus.cs_n && bus.rd_n && !bus.wr_n;
  assign w_wrPulse  = w_writeSel && !r_writeSelQ;
  assign w_rdEnd    = r_readSelQ && !w_readSel;
  // On the first read cycle the latched address is not yet valid, so use the live one.
  assign w_rdAddr   = (w_readSel && !r_readSelQ) ? bus.addr : r_rdAddr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readSelQ  <= 1'b0;
      r_writeSelQ <= 1'b0;
      r_rdAddr    <= '0;
    end else begin
      r_readSelQ  <= w_readSel;
      r_writeSelQ <= w_writeSel;
      if (w_readSel && !r_readSelQ)
        r_rdAddr <= bus.addr;
    end
  end

  assign w_ctrlWr     = w_wrPulse && (bus.addr == 3'd1);
  assign w_txFlush    = w_ctrlWr && bus.data_in[2];
  assign w_rxFlush    = w_ctrlWr && bus.data_in[3];
  assign w_overrunClr = w_ctrlWr && bus.data_in[4];

  assign w_rxEmpty = (r_rxWr == r_rxRd);
  assign w_rxFull  = (r_rxWr[RX_AW] != r_rxRd[RX_AW]) &&
                     (r_rxWr[RX_AW-1:0] == r_rxRd[RX_AW-1:0]);
  assign w_rxCount = r_rxWr - r_rxRd;
  assign w_rxPop   = w_rdEnd && (r_rdAddr == 3'd2) && !w_rxEmpty;
  assign w_rxPush  = bus.core_rx_strobe && (!w_rxFull || w_rxPop);
  assign w_rxDrop  = bus.core_rx_strobe && w_rxFull && !w_rxPop;

  assign w_txEmpty = (r_txWr == r_txRd);
  assign w_txFull  = (r_txWr[TX_AW] != r_txRd[TX_AW]) &&
                     (r_txWr[TX_AW-1:0] == r_txRd[TX_AW-1:0]);
  assign w_txFree  = {1'b1, {TX_AW{1'b0}}} - (r_txWr - r_txRd);
  assign w_txPop   = (r_state == SEND);
  assign w_txPush  = w_wrPulse && (bus.addr == 3'd3) && (!w_txFull || w_txPop);

  always_ff @(posedge clk) begin
    if (w_rxPush)
      r_rxMem[r_rxWr[RX_AW-1:0]] <= bus.core_rx_data;
    if (w_txPush)
      r_txMem[r_txWr[TX_AW-1:0]] <= bus.data_in;
  end

  // Flush takes priority over any push or pop on the same FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rxWr <= '0;
      r_rxRd <= '0;
      r_txWr <= '0;
      r_txRd <= '0;
    end else begin
      if (w_rxFlush) begin
        r_rxWr <= '0;
        r_rxRd <= '0;
      end else begin
        if (w_rxPush) r_rxWr <= r_rxWr + 1'b1;
        if (w_rxPop)  r_rxRd <= r_rxRd + 1'b1;
      end
      if (w_txFlush) begin
        r_txWr <= '0;
        r_txRd <= '0;
      end else begin
        if (w_txPush) r_txWr <= r_txWr + 1'b1;
        if (w_txPop)  r_txRd <= r_txRd + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rxIrqEn <= 1'b0;
      r_txIrqEn <= 1'b0;
      r_overrun <= 1'b0;
      r_irqN    <= 1'b1;
    end else begin
      if (w_ctrlWr) begin
        r_rxIrqEn <= bus.data_in[0];
        r_txIrqEn <= bus.data_in[1];
      end
      if (w_rxDrop)
        r_overrun <= 1'b1;
      else if (w_overrunClr)
        r_overrun <= 1'b0;
      r_irqN <= !w_irqPending;
    end
  end

  // A flush arriving in IDLE must not launch a byte that is about to vanish.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_txStrobe <= 1'b0;
      r_txData   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_txEmpty && bus.core_tx_ready && !w_txFlush) begin
            r_state    <= SEND;
            r_txStrobe <= 1'b1;
            r_txData   <= r_txMem[r_txRd[TX_AW-1:0]];
          end else begin
            r_txStrobe <= 1'b0;
          end
        end
        SEND: begin
          r_state    <= GAP;
          r_txStrobe <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_txStrobe <= 1'b0;
        end
      endcase
    end
  end

  assign w_irqPending = (r_rxIrqEn && (!w_rxEmpty || r_overrun)) || (r_txIrqEn && w_txEmpty);

  always_comb begin
    w_rdData = '0;
    if (w_readSel) begin
      case (w_rdAddr)
        3'd0:    w_rdData = {{(DATA_W-5){1'b0}}, w_irqPending, w_txEmpty, r_overrun,
                             !w_txFull, !w_rxEmpty};
        3'd1:    w_rdData = {{(DATA_W-2){1'b0}}, r_txIrqEn, r_rxIrqEn};
        3'd2:    w_rdData = w_rxEmpty ? '0 : r_rxMem[r_rxRd[RX_AW-1:0]];
        3'd4:    w_rdData = {{(DATA_W-RX_AW-1){1'b0}}, w_rxCount};
        3'd5:    w_rdData = {{(DATA_W-TX_AW-1){1'b0}}, w_txFree};
        default: w_rdData = '0;
      endcase
    end
  end

  assign bus.data_out       = w_rdData;
  assign bus.irq_n          = r_irqN;
  assign bus.core_tx_strobe = r_txStrobe;
  assign bus.core_tx_data   = r_txData;

endmodule
